// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            E_start,
  input  logic [2:0]      E_funct3,
  input  logic [XLEN-1:0] E_rs1_val,
  input  logic [XLEN-1:0] E_rs2_val,
  input  logic [4:0]      E_rf_a3,
  output logic            E_stall,
  output logic            M_done,
  output logic [XLEN-1:0] M_result,
  output logic [4:0]      M_rf_a3
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        f3;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;   // product, or remainder in the low word
  logic [2*XLEN-1:0] opb;   // shifting multiplicand, or divisor in the low word
  logic [XLEN-1:0]   opa;   // shifting multiplier, or dividend turning into quotient
  logic              neg_q;
  logic              neg_r;

  logic            start_ok;
  logic            in_div;
  logic            s1;
  logic            s2;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            div_ovf;

  assign start_ok = E_start & ~clr;
  assign in_div   = E_funct3[2];
  assign s1       = in_div ? ~E_funct3[0] : (E_funct3[1:0] == 2'b01 || E_funct3[1:0] == 2'b10);
  assign s2       = in_div ? ~E_funct3[0] : (E_funct3[1:0] == 2'b01);
  assign neg1     = s1 & E_rs1_val[XLEN-1];
  assign neg2     = s2 & E_rs2_val[XLEN-1];
  assign mag1     = neg1 ? -E_rs1_val : E_rs1_val;
  assign mag2     = neg2 ? -E_rs2_val : E_rs2_val;
  assign div_zero = in_div & (E_rs2_val == '0);
  assign div_ovf  = in_div & ~E_funct3[0] & (E_rs1_val == MIN_NEG) & (E_rs2_val == '1);

  // Restoring divide step: shift the next dividend bit into the partial remainder
  logic [XLEN:0]   div_trial;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  assign div_trial = {acc[XLEN-1:0], opa[XLEN-1]};
  assign div_ge    = div_trial >= {1'b0, opb[XLEN-1:0]};
  assign div_diff  = div_trial[XLEN-1:0] - opb[XLEN-1:0];

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   res_sel;

  assign prod_s = neg_q ? -acc : acc;
  assign quo_s  = neg_q ? -opa : opa;
  assign rem_s  = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];

  always_comb begin
    res_sel = prod_s[XLEN-1:0];
    case (f3)
      3'b000:                 res_sel = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_sel = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_sel = quo_s;
      default:                res_sel = rem_s;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = (div_zero || div_ovf) ? SIGN : CALC;
      CALC: begin
        if (clr)                   state_nxt = IDLE;
        else if (cnt == CW'(1))    state_nxt = SIGN;
      end
      SIGN: state_nxt = clr ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      f3       <= '0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      opa      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      M_done   <= 1'b0;
      M_result <= '0;
      M_rf_a3  <= '0;
    end else begin
      M_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            f3      <= E_funct3;
            M_rf_a3 <= E_rf_a3;
            cnt     <= CW'(XLEN);
            opb     <= {{XLEN{1'b0}}, mag2};
            // Special divides preload the final answer with no sign fix-up
            if (div_zero) begin
              opa   <= '1;
              acc   <= {{XLEN{1'b0}}, E_rs1_val};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (div_ovf) begin
              opa   <= MIN_NEG;
              acc   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              opa   <= mag1;
              acc   <= '0;
              neg_q <= neg1 ^ neg2;
              neg_r <= neg1;
            end
          end
        end
        CALC: begin
          if (!clr) begin
            cnt <= cnt - CW'(1);
            if (f3[2]) begin
              acc <= {{XLEN{1'b0}}, div_ge ? div_diff : div_trial[XLEN-1:0]};
              opa <= {opa[XLEN-2:0], div_ge};
            end else begin
              if (opa[0]) acc <= acc + opb;
              opb <= opb << 1;
              opa <= opa >> 1;
            end
          end
        end
        SIGN: begin
          if (!clr) begin
            M_result <= res_sel;
            M_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign E_stall = (state == IDLE && start_ok) || state == CALC || state == SIGN;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        E_start = 1'b0;
  logic [2:0]  E_funct3 = '0;
  logic [31:0] E_rs1_val = '0;
  logic [31:0] E_rs2_val = '0;
  logic [4:0]  E_rf_a3 = '0;
  logic        E_stall;
  logic        M_done;
  logic [31:0] M_result;
  logic [4:0]  M_rf_a3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t exp_q[$];

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .E_start(E_start), .E_funct3(E_funct3),
    .E_rs1_val(E_rs1_val), .E_rs2_val(E_rs2_val), .E_rf_a3(E_rf_a3),
    .E_stall(E_stall), .M_done(M_done), .M_result(M_result), .M_rf_a3(M_rf_a3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    ref_model = '0;
    case (f)
      3'd0: begin p = sa * sb; ref_model = p[31:0]; end
      3'd1: begin p = sa * sb; ref_model = p[63:32]; end
      3'd2: begin p = sa * ub; ref_model = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; ref_model = p[63:32]; end
      3'd4: ref_model = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
      3'd5: ref_model = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: ref_model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one instruction at a falling edge and holds it until M_done or timeout
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output int stalls,
                       output logic [31:0] res, output logic [4:0] rdo,
                       output logic got, output logic stall_in_done);
    E_start = 1'b1; E_funct3 = f; E_rs1_val = a; E_rs2_val = b; E_rf_a3 = rd;
    #1;
    lat = 0; stalls = 0; got = 1'b0; res = 'x; rdo = 'x; stall_in_done = 1'bx;
    for (int i = 0; i < 60; i++) begin
      if (E_stall) stalls++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (M_done) begin
        got = 1'b1; res = M_result; rdo = M_rf_a3; stall_in_done = E_stall;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; E_start = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (M_done !== 1'b0)    begin n_fail++; $display("FAIL reset M_done: got %b want 0", M_done); end
    n_checks++; if (M_result !== 32'h0) begin n_fail++; $display("FAIL reset M_result: got %h want 0", M_result); end
    n_checks++; if (M_rf_a3 !== 5'h0)   begin n_fail++; $display("FAIL reset M_rf_a3: got %h want 0", M_rf_a3); end
    n_checks++; if (E_stall !== 1'b0)   begin n_fail++; $display("FAIL reset E_stall: got %b want 0", E_stall); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int lat, stalls; logic [31:0] res; logic [4:0] rdo; logic got, sd; exp_t e;
    exp_q.push_back('{32'hFFFFFFEB, 5'd5, 34});
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, lat, stalls, res, rdo, got, sd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL mul_basic done: no M_done within 60 cycles"); end
    else begin
      n_checks++; if (res !== e.res)    begin n_fail++; $display("FAIL mul_basic result: got %h want %h", res, e.res); end
      n_checks++; if (rdo !== e.rd)     begin n_fail++; $display("FAIL mul_basic rd: got %0d want %0d", rdo, e.rd); end
      n_checks++; if (lat != e.lat)     begin n_fail++; $display("FAIL mul_basic latency: got %0d want %0d", lat, e.lat); end
      n_checks++; if (stalls != 34)     begin n_fail++; $display("FAIL mul_basic stall cycles: got %0d want 34", stalls); end
      n_checks++; if (sd !== 1'b0)      begin n_fail++; $display("FAIL mul_basic stall in done: got %b want 0", sd); end
    end
    E_start = 1'b0;
    @(negedge clk);
    n_checks++; if (M_done !== 1'b0) begin n_fail++; $display("FAIL mul_basic pulse width: got %b want 0", M_done); end
  endtask

  task automatic test_mul_high();
    vec_t v[4]; int lat, stalls; logic [31:0] res; logic [4:0] rdo; logic got, sd; exp_t e;
    v[0] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 34};
    v[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000, 34};
    v[2] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF, 34};
    v[3] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h00000001, 34};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{v[i].res, v[i].rd, v[i].lat});
      do_op(v[i].f, v[i].a, v[i].b, v[i].rd, lat, stalls, res, rdo, got, sd);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL mul_high[%0d] done: no M_done", i); end
      else begin
        n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL mul_high[%0d] result: got %h want %h", i, res, e.res); end
        n_checks++; if (rdo !== e.rd)  begin n_fail++; $display("FAIL mul_high[%0d] rd: got %0d want %0d", i, rdo, e.rd); end
        n_checks++; if (lat != e.lat)  begin n_fail++; $display("FAIL mul_high[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      end
      E_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_divide();
    vec_t v[10]; int lat, stalls; logic [31:0] res; logic [4:0] rdo; logic got, sd; exp_t e;
    v[0] = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd1, 32'hFFFFFFFD, 34};
    v[1] = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd2, 32'hFFFFFFFF, 34};
    v[2] = '{3'd5, 32'd100,      32'd7,        5'd3, 32'd14,       34};
    v[3] = '{3'd7, 32'd100,      32'd7,        5'd4, 32'd2,        34};
    v[4] = '{3'd4, 32'd5,        32'd0,        5'd5, 32'hFFFFFFFF, 2};
    v[5] = '{3'd6, 32'd5,        32'd0,        5'd6, 32'd5,        2};
    v[6] = '{3'd5, 32'hFFFFFFF9, 32'd0,        5'd7, 32'hFFFFFFFF, 2};
    v[7] = '{3'd7, 32'hFFFFFFF9, 32'd0,        5'd8, 32'hFFFFFFF9, 2};
    v[8] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 2};
    v[9] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, 2};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{v[i].res, v[i].rd, v[i].lat});
      do_op(v[i].f, v[i].a, v[i].b, v[i].rd, lat, stalls, res, rdo, got, sd);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL divide[%0d] done: no M_done", i); end
      else begin
        n_checks++; if (res !== e.res)   begin n_fail++; $display("FAIL divide[%0d] result: got %h want %h", i, res, e.res); end
        n_checks++; if (rdo !== e.rd)    begin n_fail++; $display("FAIL divide[%0d] rd: got %0d want %0d", i, rdo, e.rd); end
        n_checks++; if (lat != e.lat)    begin n_fail++; $display("FAIL divide[%0d] latency: got %0d want %0d", i, lat, e.lat); end
        n_checks++; if (stalls != e.lat) begin n_fail++; $display("FAIL divide[%0d] stall cycles: got %0d want %0d", i, stalls, e.lat); end
      end
      E_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int lat, stalls; logic [31:0] res, a, b; logic [4:0] rdo, rd; logic [2:0] f; logic got, sd; exp_t e;
    for (int i = 0; i < 10; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      rd = 5'($urandom_range(1, 31));
      exp_q.push_back('{ref_model(f, a, b), rd,
                        (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 2 : 34});
      do_op(f, a, b, rd, lat, stalls, res, rdo, got, sd);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL random[%0d] done: no M_done", i); end
      else begin
        n_checks++;
        if (res !== e.res) begin n_fail++; $display("FAIL random[%0d] f3=%0d a=%h b=%h result: got %h want %h", i, f, a, b, res, e.res); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      end
      E_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_clr();
    logic [31:0] prev; int dones;
    prev = M_result;
    E_start = 1'b1; E_funct3 = 3'd0; E_rs1_val = 32'd9; E_rs2_val = 32'd9; E_rf_a3 = 5'd20;
    repeat (11) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; E_start = 1'b0;
    #1;
    n_checks++; if (E_stall !== 1'b0) begin n_fail++; $display("FAIL clr E_stall: got %b want 0", E_stall); end
    n_checks++; if (M_done !== 1'b0)  begin n_fail++; $display("FAIL clr M_done: got %b want 0", M_done); end
    n_checks++; if (M_result !== prev) begin n_fail++; $display("FAIL clr M_result: got %h want %h", M_result, prev); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (M_done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL clr stray done: got %0d pulses want 0", dones); end
    // clr in IDLE must block the start
    E_start = 1'b1; clr = 1'b1;
    #1;
    n_checks++; if (E_stall !== 1'b0) begin n_fail++; $display("FAIL clr_idle E_stall: got %b want 0", E_stall); end
    @(negedge clk);
    E_start = 1'b0; clr = 1'b0;
    #1;
    n_checks++; if (E_stall !== 1'b0) begin n_fail++; $display("FAIL clr_idle state: E_stall got %b want 0", E_stall); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    E_start = 1'b1; E_funct3 = 3'd4; E_rs1_val = 32'd1000; E_rs2_val = 32'd3; E_rf_a3 = 5'd17;
    repeat (11) @(negedge clk);
    rst = 1'b0; E_start = 1'b0;
    @(negedge clk);
    n_checks++; if (M_done !== 1'b0)    begin n_fail++; $display("FAIL rst_mid M_done: got %b want 0", M_done); end
    n_checks++; if (M_result !== 32'h0) begin n_fail++; $display("FAIL rst_mid M_result: got %h want 0", M_result); end
    n_checks++; if (M_rf_a3 !== 5'h0)   begin n_fail++; $display("FAIL rst_mid M_rf_a3: got %h want 0", M_rf_a3); end
    n_checks++; if (E_stall !== 1'b0)   begin n_fail++; $display("FAIL rst_mid E_stall: got %b want 0", E_stall); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, stalls; logic [31:0] res; logic [4:0] rdo; logic got, sd; exp_t e;
    exp_q.push_back('{32'd12, 5'd1, 34});
    exp_q.push_back('{32'd30, 5'd2, 35});
    do_op(3'd0, 32'd3, 32'd4, 5'd1, lat, stalls, res, rdo, got, sd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL b2b first done: no M_done"); end
    else begin
      n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL b2b first result: got %h want %h", res, e.res); end
      n_checks++; if (lat != e.lat)  begin n_fail++; $display("FAIL b2b first latency: got %0d want %0d", lat, e.lat); end
    end
    // Second instruction is presented while the unit sits in DONE
    do_op(3'd0, 32'd5, 32'd6, 5'd2, lat, stalls, res, rdo, got, sd);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL b2b second done: no M_done"); end
    else begin
      n_checks++; if (res !== e.res)  begin n_fail++; $display("FAIL b2b second result: got %h want %h", res, e.res); end
      n_checks++; if (rdo !== e.rd)   begin n_fail++; $display("FAIL b2b second rd: got %0d want %0d", rdo, e.rd); end
      n_checks++; if (lat != e.lat)   begin n_fail++; $display("FAIL b2b pulse spacing: got %0d want %0d", lat, e.lat); end
      n_checks++; if (stalls != 34)   begin n_fail++; $display("FAIL b2b second stall cycles: got %0d want 34", stalls); end
    end
    E_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_high();
    test_divide();
    test_random();
    test_clr();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
